mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Sequential shift-add multiplier that executes MIPS mult/multu and writes the 64-bit HI/LO pair.
- Sits downstream of the 32-bit ripple adder. Each iteration it adds the multiplicand to the upper half of the running product and keeps the adder's carry-out as bit 32.
- Sits beside the ALU; the control unit stalls on busy until done.

Parameters:
WIDTH, 32, operand width; hi/lo are each WIDTH bits; only 32 is supported (matches the 32-bit adder)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = mult (two's complement), 0 = multu
a  input  WIDTH  multiplicand (rs)
b  input  WIDTH  multiplier (rt)
busy  output  1  high from the edge that accepts start until the edge that writes the result
done  output  1  registered one-cycle pulse: hi/lo valid
hi  output  WIDTH  upper product word
lo  output  WIDTH  lower product word

Behaviour:
- Reset: reset sampled high at a rising edge gives state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, and all internal registers cleared.
- Reset takes priority over everything and aborts any operation in flight; hi/lo are cleared, not partially updated.
- States: IDLE, RUN, SIGN.
- IDLE:
  - done is driven low every cycle, except on the cycle after the SIGN edge.
  - On start = 1 at an edge: latch mcand = |a| and mplier = |b| (magnitude only when signed_op = 1, else raw).
  - Latch neg = signed_op & (a[31] ^ b[31]).
  - Clear prod_hi (33 bits, includes carry), load prod_lo = mplier, clear the 5-bit counter.
  - Set busy = 1 and go to RUN.
- Magnitude of 0x80000000 is 0x80000000 (unsigned 32-bit).
- RUN, one iteration per edge:
  - If prod_lo[0] = 1: {carry, sum} = prod_hi[31:0] + mcand (33-bit result); else the sum is prod_hi[31:0] with carry 0.
  - Then shift {carry, sum, prod_lo} right by 1 into {prod_hi, prod_lo}.
  - Increment the counter; after 32 iterations (counter wraps 31 -> 0 on the last iteration) go to SIGN.
- SIGN, one edge:
  - {hi, lo} = neg ? (~P + 1) : P, where P = {prod_hi[31:0], prod_lo}, a 64-bit two's-complement negation.
  - busy = 0, done = 1, go to IDLE.
- Latency: start sampled at edge E0; 32 RUN edges E1..E32; result written at E33; done high for exactly one cycle after E33. Total 34 edges per operation.
- start while busy (RUN/SIGN): ignored, no queueing; operands are not re-sampled.
- a, b and signed_op may change freely after E0.
- Back-to-back: state is IDLE during the done cycle, so start asserted in that cycle is accepted at the next edge. done then falls and busy rises on the same edge.
- hi/lo hold their last value until the next SIGN edge; they change only at SIGN or reset.
- No overflow is possible: the 64-bit product always fits.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then multu a = 0xFFFFFFFF, b = 0xFFFFFFFF, start one cycle -> busy for 33 cycles; done pulses 1 cycle; hi = 0xFFFFFFFE, lo = 0x00000001.
- mult a = 0xFFFFFFFD (-3), b = 0x00000007 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21); mult a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
- Operand zero: mult a = 0, b = 0x80000000 -> hi = 0, lo = 0, neg path produces +0; multu a = 0x00010000, b = 0x00010000 -> hi = 0x00000001, lo = 0.
- start pulsed again at cycle 10 of a run with different a/b -> ignored; original result returned at the same cycle; only one done pulse.
- reset asserted at cycle 15 of a run -> next cycle busy = 0, done = 0, hi = lo = 0; a subsequent start completes normally after 34 edges.
- start held high continuously with a = 3, b = 5 -> done every 34 cycles; hi = 0, lo = 15; start on the done cycle is accepted with no idle gap.

Source files
------------

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier for MIPS mult/multu: one add/shift iteration per clock,
// then a sign-fixup cycle that writes the 64-bit HI/LO pair.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     r_prod_hi;
    logic [WIDTH-1:0]   r_prod_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_shifted;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_result;
    logic               w_last_iter;

    // Unary minus of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign w_a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

    // prod_hi[WIDTH] is always 0 entering an iteration, so the adder carry-out lands in bit WIDTH.
    assign w_addend  = r_prod_lo[0] ? {1'b0, r_mcand} : '0;
    assign w_sum     = r_prod_hi + w_addend;
    assign w_shifted = {w_sum, r_prod_lo} >> 1;

    assign w_product   = {r_prod_hi[WIDTH-1:0], r_prod_lo};
    assign w_result    = r_neg ? (~w_product + (2*WIDTH)'(1)) : w_product;
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last_iter) w_next_state = SIGN;
            SIGN:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand   <= w_a_mag;
                        r_prod_hi <= '0;
                        r_prod_lo <= w_b_mag;
                        r_cnt     <= '0;
                        r_neg     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_busy    <= 1'b1;
                    end
                end
                RUN: begin
                    {r_prod_hi, r_prod_lo} <= w_shifted;
                    r_cnt                  <= r_cnt + CNT_W'(1);
                end
                SIGN: begin
                    {r_hi, r_lo} <= w_result;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: expected products are queued at issue time
// from a 64-bit arithmetic model and compared when done pulses.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q[$];

    mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (s) return 64'(sx * sy);
        return 64'(ux * uy);
    endfunction

    // Drives start for one cycle; returns at the falling edge after the accepting edge.
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        a         = x;
        b         = y;
        exp_q.push_back(model(s, x, y));
        @(negedge clk);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        signed_op = 1'($urandom_range(0, 1));
    endtask

    // k counts falling edges since the accepting edge; bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int k, output int busy_cnt);
        k        = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++;
        if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_vec++;
        if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_multu_max;
        int          k;
        int          busy_cnt;
        logic [63:0] exp;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, busy_cnt);
        n_vec++;
        if (k != 34) begin n_err++; $display("FAIL max_latency: got %0d want 34", k); end
        n_vec++;
        if (busy_cnt != 33) begin n_err++; $display("FAIL max_busy_cycles: got %0d want 33", busy_cnt); end
        exp = exp_q.pop_front();
        n_vec++;
        if ({hi, lo} !== exp) begin n_err++; $display("FAIL max_result: got %h want %h", {hi, lo}, exp); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL max_busy_at_done: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL max_done_pulse: got %b want 0", done); end
        n_vec++;
        if ({hi, lo} !== exp) begin n_err++; $display("FAIL max_hold: got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_patterns;
        logic        tbl_s[8];
        logic [31:0] tbl_a[8];
        logic [31:0] tbl_b[8];
        int          k;
        int          busy_cnt;
        logic [63:0] exp;
        tbl_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl_a = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h0000_0000, 32'h0001_0000,
                  32'h7FFF_FFFF, 32'h8000_0000, $urandom, $urandom};
        tbl_b = '{32'h0000_0007, 32'h8000_0000, 32'h8000_0000, 32'h0001_0000,
                  32'h8000_0001, 32'h0000_0003, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            issue(tbl_s[i], tbl_a[i], tbl_b[i]);
            wait_done(k, busy_cnt);
            exp = exp_q.pop_front();
            n_vec++;
            if (k != 34 || {hi, lo} !== exp) begin
                n_err++;
                $display("FAIL pattern_%0d: got %h after %0d edges want %h after 34", i, {hi, lo}, k, exp);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int          n_done;
        int          done_k;
        logic [63:0] exp;
        n_done = 0;
        done_k = 0;
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int k = 2; k <= 80; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_k = k;
                    exp = exp_q.pop_front();
                    n_vec++;
                    if ({hi, lo} !== exp) begin n_err++; $display("FAIL busy_ignore_result: got %h want %h", {hi, lo}, exp); end
                end
            end
            if (k == 10) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                b     = 32'hFFFF_FFFF;
            end
            if (k == 11) start = 1'b0;
        end
        n_vec++;
        if (n_done != 1) begin n_err++; $display("FAIL busy_ignore_pulses: got %0d want 1", n_done); end
        n_vec++;
        if (done_k != 34) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 34", done_k); end
    endtask

    task automatic test_reset_mid;
        int          k;
        int          busy_cnt;
        logic [63:0] exp;
        issue(1'b1, 32'hFFFF_0000, 32'h0000_1234);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        n_vec++;
        if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
        issue(1'b1, 32'hFFFF_FFFB, 32'h0000_0009);
        wait_done(k, busy_cnt);
        exp = exp_q.pop_front();
        n_vec++;
        if (k != 34 || {hi, lo} !== exp) begin
            n_err++;
            $display("FAIL midreset_recover: got %h after %0d edges want %h after 34", {hi, lo}, k, exp);
        end
    endtask

    task automatic test_back_to_back;
        int          k;
        int          last_k;
        int          n_done;
        logic [63:0] exp;
        k      = 0;
        last_k = 0;
        n_done = 0;
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        a         = 32'd3;
        b         = 32'd5;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(1'b0, 32'd3, 32'd5));
        while (n_done < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (done) begin
                n_done++;
                exp = exp_q.pop_front();
                n_vec++;
                if ({hi, lo} !== exp) begin n_err++; $display("FAIL b2b_result_%0d: got %h want %h", n_done, {hi, lo}, exp); end
                n_vec++;
                if (k - last_k != 34) begin n_err++; $display("FAIL b2b_period_%0d: got %0d want 34", n_done, k - last_k); end
                last_k = k;
                if (n_done == 3) begin
                    start = 1'b0;
                end else begin
                    @(negedge clk);
                    k++;
                    n_vec++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        n_err++;
                        $display("FAIL b2b_no_gap_%0d: got busy=%b done=%b want 1 0", n_done, busy, done);
                    end
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (n_done != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", n_done); end
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_vec++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stop: got %0d extra done pulses busy=%b want 0 0", n_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_patterns();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
